// File: rtl/axis_fifo_buf.sv
// AXI4-Stream FIFO with first-word-fall-through registered output and full sideband set.
// Define AXIS_FIFO_BUF_PACKET_MODE_EN to build the store-and-forward packet mode.
module axis_fifo_buf #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 8,
    parameter int USER_W = 0,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1,
    localparam int KEEP_W = DATA_W / 8,
    localparam int UW     = (USER_W > 0) ? USER_W : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic [ID_W-1:0]   s_axis_tid,
    input  logic [ID_W-1:0]   s_axis_tdest,
    input  logic [UW-1:0]     s_axis_tuser,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic [ID_W-1:0]   m_axis_tid,
    output logic [ID_W-1:0]   m_axis_tdest,
    output logic [UW-1:0]     m_axis_tuser,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = UW + 2 * ID_W + 1 + KEEP_W + DATA_W;

    logic [PW-1:0] mem [DEPTH];
    logic [PW-1:0] in_word;
    logic [PW-1:0] out_word;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [UW-1:0] user_in;
    logic          push;
    logic          pop;
    logic          release_out;

    generate
        if (USER_W > 0) begin : g_user
            assign user_in = s_axis_tuser;
        end else begin : g_no_user
            logic unused_tuser;
            assign unused_tuser = ^s_axis_tuser;
            assign user_in      = '0;
        end
    endgenerate

    assign in_word = {user_in, s_axis_tdest, s_axis_tid, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    assign {m_axis_tuser, m_axis_tdest, m_axis_tid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_word;

    // Flags come straight from the count register, so ready never depends on m_axis_tready.
    assign full          = (count == CNT_W'(DEPTH));
    assign empty         = (count == '0);
    assign s_axis_tready = !full;
    assign m_axis_tvalid = !empty && release_out;
    assign push          = s_axis_tvalid && !full;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign rd_next       = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_word;
        end
    end

    // out_word always mirrors the head entry; it is refilled from the array or the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_word <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop) begin
                if (count >= CNT_W'(2)) begin
                    out_word <= mem[rd_next];
                end else if (push) begin
                    out_word <= in_word;
                end
            end else if (empty && push) begin
                out_word <= in_word;
            end
        end
    end

`ifdef AXIS_FIFO_BUF_PACKET_MODE_EN
    logic [CNT_W-1:0] pkt_cnt;
    logic             in_pkt;
    logic             push_last;
    logic             pop_last;

    assign push_last = push && s_axis_tlast;
    assign pop_last  = pop && m_axis_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
            in_pkt  <= 1'b0;
        end else begin
            case ({push_last, pop_last})
                2'b10:   pkt_cnt <= pkt_cnt + CNT_W'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CNT_W'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
            if (pop) begin
                in_pkt <= !m_axis_tlast;
            end
        end
    end

    // A full buffer with no complete packet would deadlock, so it drains cut-through;
    // in_pkt then keeps the output open until that packet's tlast leaves.
    assign release_out = (pkt_cnt != '0) || in_pkt || full;
`else
    assign release_out = 1'b1;
`endif

endmodule

// File: tb/tb_axis_fifo_buf.sv
// Self-checking bench for axis_fifo_buf: queue-based reference model, randomized traffic.
// Packet-mode scenarios are built when AXIS_FIFO_BUF_PACKET_MODE_EN is defined.
module tb_axis_fifo_buf;
    localparam int DATA_W = 32;
    localparam int ID_W   = 8;
    localparam int USER_W = 0;
    localparam int DEPTH  = 16;
    localparam int KEEP_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WW     = 1 + 2 * ID_W + 1 + KEEP_W + DATA_W;
    localparam int LAST   = DATA_W + KEEP_W;

    typedef logic [WW-1:0] word_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s_tdata;
    logic [KEEP_W-1:0] s_tkeep;
    logic              s_tlast;
    logic [ID_W-1:0]   s_tid;
    logic [ID_W-1:0]   s_tdest;
    logic [0:0]        s_tuser;
    logic              s_tvalid;
    logic              s_tready;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tlast;
    logic [ID_W-1:0]   m_tid;
    logic [ID_W-1:0]   m_tdest;
    logic [0:0]        m_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    int    checks   = 0;
    int    failures = 0;
    word_t mq[$];
    bit    mid_pkt;

    axis_fifo_buf #(.DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tid(m_tid), .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected output word; tuser is never stored with USER_W=0, so it is always 0.
    function automatic word_t mk(input logic [31:0] d, input logic [3:0] k, input logic l,
                                 input logic [7:0] id, input logic [7:0] dest);
        return {1'b0, dest, id, l, k, d};
    endfunction

    function automatic word_t dut_word();
        return {m_tuser, m_tdest, m_tid, m_tlast, m_tkeep, m_tdata};
    endfunction

    function automatic bit exp_valid();
        int nl;
        nl = 0;
        if (mq.size() == 0) return 1'b0;
`ifdef AXIS_FIFO_BUF_PACKET_MODE_EN
        foreach (mq[i]) if (mq[i][LAST]) nl++;
        return (nl > 0) || mid_pkt || (mq.size() == DEPTH);
`else
        return 1'b1 | (nl != 0);
`endif
    endfunction

    task automatic set_in(input word_t w, input logic v);
        s_tdata  = w[DATA_W-1:0];
        s_tkeep  = w[DATA_W+KEEP_W-1:DATA_W];
        s_tlast  = w[LAST];
        s_tid    = w[LAST+ID_W:LAST+1];
        s_tdest  = w[LAST+2*ID_W:LAST+ID_W+1];
        s_tuser  = 1'($urandom);
        s_tvalid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances one clock edge and moves the reference queue by the transfers that edge makes.
    task automatic cycle(output bit did_push, output bit did_pop, output word_t exp_w, output word_t got_w);
        word_t in_w;
        in_w     = mk(s_tdata, s_tkeep, s_tlast, s_tid, s_tdest);
        did_push = s_tvalid && (mq.size() < DEPTH);
        did_pop  = exp_valid() && m_tready;
        got_w    = dut_word();
        exp_w    = did_pop ? mq[0] : '0;
        tick();
        if (did_pop) begin
            mid_pkt = !mq[0][LAST];
            mq.delete(0);
        end
        if (did_push) mq.push_back(in_w);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in('0, 1'b0);
        m_tready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        mq.delete();
        mid_pkt = 1'b0;
    endtask

    function automatic word_t rnd_word(input logic [31:0] d, input logic l);
        logic [31:0] r;
        r = $urandom;
        return mk(d, r[3:0], l, r[15:8], r[23:16]);
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL reset_tready got=%b exp=1", s_tready); end
        checks++; if (m_tlast !== 1'b0 || m_tuser !== 1'b0) begin failures++; $display("FAIL reset_last_user got=%b%b exp=00", m_tlast, m_tuser); end
    endtask

    task automatic test_single();
        word_t w, e, g;
        bit    dp, dq;
        do_reset();
        w = mk(32'hA5A5A5A5, 4'hF, 1'b1, 8'd3, 8'd5);
        m_tready = 1'b1;
        set_in(w, 1'b1);
        cycle(dp, dq, e, g);
        s_tvalid = 1'b0;
        checks++; if (m_tvalid !== 1'b1) begin failures++; $display("FAIL single_tvalid got=%b exp=1", m_tvalid); end
        checks++; if (dut_word() !== w) begin failures++; $display("FAIL single_payload got=%h exp=%h", dut_word(), w); end
        checks++; if (count !== CNT_W'(1)) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count); end
        cycle(dp, dq, e, g);
        checks++; if (!dq || g !== w) begin failures++; $display("FAIL single_pop pop=%b got=%h exp=%h", dq, g, w); end
        checks++; if (count !== '0 || empty !== 1'b1) begin failures++; $display("FAIL single_count0 got=%0d empty=%b exp=0/1", count, empty); end
    endtask

    task automatic test_fill();
        word_t e, g;
        bit    dp, dq;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(rnd_word(32'(i), i == DEPTH - 1), 1'b1);
            cycle(dp, dq, e, g);
            checks++; if (count !== CNT_W'(i + 1)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
        end
        checks++; if (full !== 1'b1 || s_tready !== 1'b0) begin failures++; $display("FAIL fill_full full=%b tready=%b exp=1/0", full, s_tready); end
        set_in(rnd_word(32'd99, 1'b1), 1'b1);
        cycle(dp, dq, e, g);
        checks++; if (count !== CNT_W'(DEPTH)) begin failures++; $display("FAIL fill_17th count=%0d exp=%0d", count, DEPTH); end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(dp, dq, e, g);
            checks++; if (!dq || g[DATA_W-1:0] !== 32'(i) || g !== e) begin failures++; $display("FAIL drain_order pop=%b got=%h exp_data=%0d", dq, g, i); end
        end
        checks++; if (empty !== 1'b1 || m_tvalid !== 1'b0) begin failures++; $display("FAIL drain_empty empty=%b tvalid=%b exp=1/0", empty, m_tvalid); end
    endtask

    task automatic test_simultaneous();
        word_t e, g;
        bit    dp, dq;
        int    k;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(rnd_word(32'(100 + i), 1'b1), 1'b1);
            cycle(dp, dq, e, g);
        end
        m_tready = 1'b1;
        k = 0;
        for (int j = 0; j < 20; j++) begin
            set_in(rnd_word(32'(200 + j), 1'b1), 1'b1);
            cycle(dp, dq, e, g);
            checks++; if (count !== CNT_W'(8)) begin failures++; $display("FAIL simul_count got=%0d exp=8", count); end
            checks++;
            if (!dq || g !== e || g[DATA_W-1:0] !== ((k < 8) ? 32'(100 + k) : 32'(200 + k - 8))) begin
                failures++; $display("FAIL simul_seq pop=%b got=%h step=%0d", dq, g, k);
            end
            k++;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic test_backpressure();
        word_t e, g, prev_w;
        bit    dp, dq, prev_stall;
        int    sent, popped;
        logic [31:0] r;
        do_reset();
        sent = 0; popped = 0; prev_stall = 1'b0; prev_w = '0;
        for (int c = 0; c < 3000 && popped < 100; c++) begin
            r = $urandom;
            if (sent < 100) set_in(rnd_word(32'(1000 + sent), (sent == 99) || (r[1:0] == 2'b00)), r[2] | r[3]);
            else s_tvalid = 1'b0;
            m_tready = r[4];
            if (prev_stall) begin
                checks++; if (m_tvalid !== 1'b1 || dut_word() !== prev_w) begin failures++; $display("FAIL bp_stable tvalid=%b got=%h exp=%h", m_tvalid, dut_word(), prev_w); end
            end
            checks++; if (m_tvalid !== exp_valid()) begin failures++; $display("FAIL bp_tvalid got=%b exp=%b", m_tvalid, exp_valid()); end
            checks++; if (count !== CNT_W'(mq.size())) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", count, mq.size()); end
            prev_stall = m_tvalid && !m_tready;
            prev_w     = dut_word();
            cycle(dp, dq, e, g);
            if (dp) sent++;
            if (dq) begin
                checks++; if (g !== e || g[DATA_W-1:0] !== 32'(1000 + popped)) begin failures++; $display("FAIL bp_order got=%h exp=%h", g, e); end
                popped++;
            end
        end
        checks++; if (popped != 100) begin failures++; $display("FAIL bp_timeout popped=%0d exp=100", popped); end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
    endtask

    task automatic test_reset_mid();
        word_t w, e, g;
        bit    dp, dq;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(rnd_word(32'(300 + i), 1'b0), 1'b1);
            cycle(dp, dq, e, g);
        end
        checks++; if (count !== CNT_W'(5)) begin failures++; $display("FAIL rmid_count5 got=%0d exp=5", count); end
        rst = 1'b1;
        s_tvalid = 1'b0;
        tick();
        rst = 1'b0;
        mq.delete();
        mid_pkt = 1'b0;
        checks++; if (count !== '0 || m_tvalid !== 1'b0 || s_tready !== 1'b1) begin failures++; $display("FAIL rmid_state count=%0d tvalid=%b tready=%b exp=0/0/1", count, m_tvalid, s_tready); end
        w = rnd_word(32'h0000BEEF, 1'b1);
        set_in(w, 1'b1);
        m_tready = 1'b1;
        cycle(dp, dq, e, g);
        s_tvalid = 1'b0;
        checks++; if (m_tvalid !== 1'b1 || dut_word() !== w) begin failures++; $display("FAIL rmid_first tvalid=%b got=%h exp=%h", m_tvalid, dut_word(), w); end
        cycle(dp, dq, e, g);
        m_tready = 1'b0;
    endtask

`ifdef AXIS_FIFO_BUF_PACKET_MODE_EN
    task automatic test_pkt_small();
        word_t e, g;
        bit    dp, dq;
        int    popped;
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(rnd_word(32'(400 + i), i == 3), 1'b1);
            cycle(dp, dq, e, g);
            s_tvalid = 1'b0;
            checks++; if (m_tvalid !== (i == 3)) begin failures++; $display("FAIL pkt4_tvalid word=%0d got=%b exp=%b", i, m_tvalid, i == 3); end
            if (i < 3) begin
                cycle(dp, dq, e, g);
                checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL pkt4_gap word=%0d got=%b exp=0", i, m_tvalid); end
            end
        end
        popped = 0;
        for (int c = 0; c < 20 && popped < 4; c++) begin
            cycle(dp, dq, e, g);
            if (dq) begin
                checks++; if (g[DATA_W-1:0] !== 32'(400 + popped) || g !== e) begin failures++; $display("FAIL pkt4_order got=%h exp=%h", g, e); end
                popped++;
            end
        end
        checks++; if (popped != 4) begin failures++; $display("FAIL pkt4_timeout popped=%0d exp=4", popped); end
    endtask

    task automatic test_pkt_big();
        word_t e, g;
        bit    dp, dq;
        int    sent, popped;
        do_reset();
        m_tready = 1'b1;
        sent = 0; popped = 0;
        for (int c = 0; c < 300 && popped < 20; c++) begin
            if (sent < 20) set_in(rnd_word(32'(500 + sent), sent == 19), 1'b1);
            else s_tvalid = 1'b0;
            checks++; if (m_tvalid !== exp_valid()) begin failures++; $display("FAIL pkt20_tvalid got=%b exp=%b count=%0d", m_tvalid, exp_valid(), count); end
            cycle(dp, dq, e, g);
            if (dp) sent++;
            if (dq) begin
                checks++; if (g[DATA_W-1:0] !== 32'(500 + popped) || g !== e) begin failures++; $display("FAIL pkt20_order got=%h exp=%h", g, e); end
                popped++;
            end
        end
        checks++; if (popped != 20) begin failures++; $display("FAIL pkt20_deadlock popped=%0d exp=20", popped); end
        s_tvalid = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        set_in('0, 1'b0);
        m_tready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_simultaneous();
        test_backpressure();
        test_reset_mid();
`ifdef AXIS_FIFO_BUF_PACKET_MODE_EN
        test_pkt_small();
        test_pkt_big();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_fifo_buf.md
Name: axis_fifo_buf

Overview:
- Parametrised AXI4-Stream FIFO buffer carrying the full sideband set: tdata, tkeep, tlast, tid, tdest, tuser.
- Sits between any AXI4-Stream master and slave as an elastic buffer or clock-cycle decoupler.
- Supersedes bare stream wiring by adding configurable depth, an occupancy count and an optional store-and-forward packet mode.
- Single clock domain.

Parameters:
DATA_W, 32, tdata width in bits; must be a multiple of 8; KEEP_W = DATA_W/8
ID_W, 8, tid and tdest width in bits; must be >= 1
USER_W, 0, tuser width in bits; 0 means no tuser is stored; port width is then 1 and m_axis_tuser is driven 0
DEPTH, 16, storage entries; power of 2, >= 4
CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override)

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  synchronous reset, active-high
s_axis_tdata  in  DATA_W  slave data
s_axis_tkeep  in  KEEP_W  slave byte enables
s_axis_tlast  in  1  slave end of packet
s_axis_tid  in  ID_W  slave stream ID
s_axis_tdest  in  ID_W  slave routing destination
s_axis_tuser  in  max(USER_W,1)  slave user sideband
s_axis_tvalid  in  1  slave valid
s_axis_tready  out  1  slave ready
m_axis_tdata/tkeep/tlast/tid/tdest/tuser  out  same widths  master payload
m_axis_tvalid  out  1  master valid
m_axis_tready  in  1  master ready
count  out  CNT_W  stored entries, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Handshakes:
  - A push occurs on cycles where s_axis_tvalid && s_axis_tready.
  - A pop occurs on cycles where m_axis_tvalid && m_axis_tready.
  - The payload of each transfer is stored or presented atomically.
- s_axis_tready = !full, registered. When full, no push is accepted even if a pop happens in the same cycle, so there is no combinational ready path from m_axis_tready.
- Output timing:
  - First-word-fall-through output.
  - A word pushed at edge N is visible with m_axis_tvalid=1 after edge N; latency is 1 cycle, with no bypass path.
- Once m_axis_tvalid is asserted, m_axis_tvalid and the payload are held stable until the pop, per AXI4-Stream rules.
- Simultaneous push and pop when not full and not empty: count is unchanged and data ordering is preserved.
- Pointers:
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
  - count is updated +1 on push only, -1 on pop only, and is unchanged on both or neither.
- Pop while empty cannot occur because m_axis_tvalid=0. Push while full cannot occur because s_axis_tready=0.
- Reset values:
  - On rst=1, pointers and count go to 0: count=0, empty=1, full=0, m_axis_tvalid=0, s_axis_tready=1 on the first cycle after reset.
  - Payload outputs are don't-care, except m_axis_tlast=0 and m_axis_tuser=0.
- Reset mid-packet discards all stored data. Partial packets are not preserved.
- Storage is inferable RAM or a register array. Output payload is registered.

Optional Feature:
- Macro: AXIS_FIFO_BUF_PACKET_MODE_EN.
- When defined (store-and-forward):
  - An internal packet counter increments on every push with tlast=1 and decrements on every pop with tlast=1; on simultaneous events it is unchanged.
  - m_axis_tvalid is asserted only while the packet counter > 0, or while a packet has already begun popping.
  - Deadlock escape: if full=1 and the packet counter == 0, the output is released in cut-through fashion until the next tlast pop.
- When undefined: pure cut-through, with no packet counter logic generated.

Test Plan:
- Reset then single word:
  - Stimulus: push tdata=0xA5A5A5A5, tkeep=0xF, tid=3, tdest=5, tlast=1 at edge N, with m_axis_tready=1.
  - Required: m_axis_tvalid=1 after edge N, identical payload, count returns 0 after the pop.
- Fill to full (DEPTH=16, m_axis_tready=0):
  - Stimulus: push 16 words 0..15.
  - Required: count=16, full=1, s_axis_tready=0. A 17th attempt is not accepted. Draining yields 0..15 in order, then empty=1.
- Simultaneous push/pop at count=8:
  - Required: count stays 8 for 20 cycles and the output sequence is continuous with no gaps or duplicates.
- Backpressure stability:
  - Stimulus: toggle m_axis_tready randomly over 100 words.
  - Required: payload is stable while tvalid=1 and tready=0, and the output matches input order exactly.
- Reset mid-operation:
  - Stimulus: assert rst with count=5.
  - Required: next cycle count=0, m_axis_tvalid=0, s_axis_tready=1. The next push is the first word seen at the output.
- Packet mode (macro defined):
  - Stimulus: push a 4-word packet with tlast on word 4, at 1 word per 2 cycles.
  - Required: m_axis_tvalid stays 0 until after the tlast push.
  - Stimulus: a 20-word packet with DEPTH=16.
  - Required: output releases once full=1, with no deadlock.
